// File: rtl/cacheline_burst_adapter_pkg.sv
// burst_types: shared FSM state encoding and line/beat geometry
package burst_types;
  localparam int BURST_W = 64;
  localparam int BEATS = 4;
  localparam int LINE_W = 256;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
endpackage

// File: rtl/cacheline_burst_adapter_line_beat_buffer.sv
// line_beat_buffer: 256-bit line register with whole-line load, beat write port and beat read mux
// Ports: clk, rst (sync, active-low), load_i/load_line_i (whole-line load),
//        wr_i/beat_i/beat_data_i (beat write), line_next_o (register next value),
//        beat_o (beat beat_i of the stored line)
module line_beat_buffer #(
  parameter int BURST_W = 64,
  parameter int BEATS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_i,
  input  logic [BURST_W*BEATS-1:0]   load_line_i,
  input  logic                       wr_i,
  input  logic [1:0]                 beat_i,
  input  logic [BURST_W-1:0]         beat_data_i,
  output logic [BURST_W*BEATS-1:0]   line_next_o,
  output logic [BURST_W-1:0]         beat_o
);
  logic [BURST_W*BEATS-1:0] line_q;
  always_comb begin
    line_next_o = load_i ? load_line_i : line_q;
    if (!load_i && wr_i) line_next_o[BURST_W*beat_i +: BURST_W] = beat_data_i;
  end
  always_ff @(posedge clk)
    if (!rst) line_q <= '0;
    else line_q <= line_next_o;
  assign beat_o = line_q[BURST_W*beat_i +: BURST_W];
endmodule

// File: rtl/cacheline_burst_adapter.sv
// cacheline_burst_adapter: splits 256-bit cache line fills/writebacks into BEATS memory beats
// Ports: clk, rst (sync, active-low)
//        cache side: line_addr_i, line_wdata_i, line_read_i, line_write_i -> line_rdata_o, line_resp_o
//        memory side: burst_addr_o, burst_wdata_o, burst_read_o, burst_write_o <- burst_rdata_i, burst_resp_i
// Macro CACHELINE_BURST_ALIGN_EN: when defined, burst_addr_o[4:0] is forced to 0 (32-byte alignment).
module cacheline_burst_adapter
  import burst_types::*;
#(
  parameter int BURST_W = 64,
  parameter int BEATS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               line_addr_i,
  input  logic [255:0]              line_wdata_i,
  input  logic                      line_read_i,
  input  logic                      line_write_i,
  output logic [255:0]              line_rdata_o,
  output logic                      line_resp_o,
  output logic [31:0]               burst_addr_o,
  input  logic [BURST_W-1:0]        burst_rdata_i,
  output logic [BURST_W-1:0]        burst_wdata_o,
  output logic                      burst_read_o,
  output logic                      burst_write_o,
  input  logic                      burst_resp_i
);
  state_t state_q, state_d;
  logic [1:0] beat_q;
  logic [31:0] addr_q;
  logic [255:0] line_next;
  logic [BURST_W-1:0] beat_rd;
  logic busy, last, leave_idle;
  assign busy = (state_q == READ) || (state_q == WRITE);
  assign last = busy && burst_resp_i && (beat_q == 2'(BEATS-1));
  assign leave_idle = (state_q == IDLE) && (line_read_i || line_write_i);
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = line_write_i ? WRITE : line_read_i ? READ : IDLE;
    else if (state_q == DONE) state_d = IDLE;
    else if (last) state_d = DONE;
  end
  line_beat_buffer #(.BURST_W(BURST_W), .BEATS(BEATS)) u_buf (
    .clk(clk),
    .rst(rst),
    .load_i((state_q == IDLE) && line_write_i),
    .load_line_i(line_wdata_i),
    .wr_i((state_q == READ) && burst_resp_i),
    .beat_i(beat_q),
    .beat_data_i(burst_rdata_i),
    .line_next_o(line_next),
    .beat_o(beat_rd)
  );
  always_ff @(posedge clk)
    if (!rst) begin
      state_q <= IDLE;
      beat_q <= '0;
      addr_q <= '0;
      line_rdata_o <= '0;
    end else begin
      state_q <= state_d;
      if (leave_idle) begin
        addr_q <= line_addr_i;
        beat_q <= '0;
      end else if (busy && burst_resp_i) beat_q <= beat_q + 2'd1;
      // publish the line together with the final beat so it is valid alongside line_resp_o
      if ((state_q == READ) && last) line_rdata_o <= line_next;
    end
  assign line_resp_o = state_q == DONE;
  assign burst_read_o = state_q == READ;
  assign burst_write_o = state_q == WRITE;
  assign burst_wdata_o = burst_write_o ? beat_rd : '0;
`ifdef CACHELINE_BURST_ALIGN_EN
  assign burst_addr_o = {addr_q[31:5], 5'b0};
`else
  assign burst_addr_o = addr_q;
`endif
endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// tb_cacheline_burst_adapter: randomized transactions against a line-level reference model
module tb_cacheline_burst_adapter;
  logic clk = 0, rst = 0;
  logic [31:0] line_addr_i = 0;
  logic [255:0] line_wdata_i = 0;
  logic line_read_i = 0, line_write_i = 0;
  logic [255:0] line_rdata_o;
  logic line_resp_o;
  logic [31:0] burst_addr_o;
  logic [63:0] burst_rdata_i = 0;
  logic [63:0] burst_wdata_o;
  logic burst_read_o, burst_write_o;
  logic burst_resp_i = 0;
  int checks = 0, errors = 0;
  logic [255:0] exp_rdata = 0;

  cacheline_burst_adapter dut (
    .clk(clk), .rst(rst),
    .line_addr_i(line_addr_i), .line_wdata_i(line_wdata_i),
    .line_read_i(line_read_i), .line_write_i(line_write_i),
    .line_rdata_o(line_rdata_o), .line_resp_o(line_resp_o),
    .burst_addr_o(burst_addr_o), .burst_rdata_i(burst_rdata_i),
    .burst_wdata_o(burst_wdata_o), .burst_read_o(burst_read_o),
    .burst_write_o(burst_write_o), .burst_resp_i(burst_resp_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [31:0] exp_addr(input logic [31:0] a);
`ifdef CACHELINE_BURST_ALIGN_EN
    return a & 32'hFFFF_FFE0;
`else
    return a;
`endif
  endfunction

  task automatic idle_chk(input string tag);
    chk({tag, "_rd"}, burst_read_o, 0);
    chk({tag, "_wr"}, burst_write_o, 0);
    chk({tag, "_resp"}, line_resp_o, 0);
    chk({tag, "_wdata"}, burst_wdata_o, 0);
    chk({tag, "_rline"}, line_rdata_o, exp_rdata);
  endtask

  // called at a negedge while the DUT is idle; returns at the negedge after it is idle again
  task automatic do_txn(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [255:0] wl, input logic [255:0] rl,
                        input int gmin, input int gmax);
    bit is_wr = wr;
    int n;
    idle_chk("pre");
    line_addr_i = a; line_wdata_i = wl; line_read_i = rd; line_write_i = wr;
    @(negedge clk);
    line_read_i = 0; line_write_i = 0;
    line_addr_i = $urandom; line_wdata_i = rand_line();
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(gmax, gmin);
      for (int g = 0; g <= n; g++) begin
        chk("busy_rd", burst_read_o, !is_wr);
        chk("busy_wr", burst_write_o, is_wr);
        chk("busy_addr", burst_addr_o, exp_addr(a));
        chk("busy_wdata", burst_wdata_o, is_wr ? wl[64*k +: 64] : 64'd0);
        chk("busy_resp", line_resp_o, 0);
        chk("busy_rline", line_rdata_o, exp_rdata);
        burst_resp_i = (g == n);
        burst_rdata_i = (g == n) ? rl[64*k +: 64] : {$urandom, $urandom};
        @(negedge clk);
      end
      burst_resp_i = 0;
    end
    if (!is_wr) exp_rdata = rl;
    chk("done_resp", line_resp_o, 1);
    chk("done_rline", line_rdata_o, exp_rdata);
    chk("done_rd", burst_read_o, 0);
    chk("done_wr", burst_write_o, 0);
    chk("done_wdata", burst_wdata_o, 0);
    burst_resp_i = 1'($urandom_range(0, 1));
    line_read_i = 1'($urandom_range(0, 1));
    @(negedge clk);
    burst_resp_i = 0; line_read_i = 0;
    idle_chk("post");
  endtask

  initial begin
    logic [255:0] l11;
    logic [31:0] a;
    bit r, w;
    repeat (2) @(negedge clk);
    chk("rst_addr", burst_addr_o, 0);
    idle_chk("rst");
    rst = 1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) l11[64*k +: 64] = {8{8'(8'h11 * (k + 1))}};
    do_txn(1, 0, 32'h0000_1234, 256'd0, l11, 0, 0);
    chk("burst_rline", line_rdata_o, {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}});
    do_txn(0, 1, 32'h0000_1234, 256'h0123456789ABCDEF_0123456789ABCDEF_0123456789ABCDEF_0123456789ABCDEF ^
           {64'h0, 64'h1111, 64'h2222, 64'h3333}, rand_line(), 2, 2);
    do_txn(1, 1, 32'hDEAD_BEEF, rand_line(), rand_line(), 0, 2);
    for (int i = 0; i < 4; i++) begin
      burst_resp_i = 1;
      @(negedge clk);
      idle_chk("idle_resp");
    end
    burst_resp_i = 0;
    for (int t = 0; t < 40; t++) begin
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      if (!r && !w) r = 1;
      do_txn(r, w, $urandom, rand_line(), rand_line(), 0, 3);
    end
    line_addr_i = 32'h0000_0040; line_read_i = 1;
    @(negedge clk);
    line_read_i = 0;
    for (int k = 0; k < 3; k++) begin
      burst_resp_i = 1; burst_rdata_i = {$urandom, $urandom};
      @(negedge clk);
    end
    burst_resp_i = 0;
    chk("mid_rd", burst_read_o, 1);
    rst = 0;
    @(negedge clk);
    exp_rdata = 0;
    chk("abort_addr", burst_addr_o, 0);
    idle_chk("abort");
    rst = 1;
    @(negedge clk);
    idle_chk("abort_after");
    do_txn(1, 0, 32'h0000_0080, 256'd0, rand_line(), 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
